// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : expr_pkg
// Description : Shared encodings for the expression-solver controller and
//               datapath: FSM state codes, mux select codes, ALU op codes.
//               The linear-mode states exist in every build. They are only
//               reachable when EXPR_LINEAR_MODE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package expr_pkg;

   // FSM state encoding
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_LOAD_X = 4'd1;
   localparam logic [3:0] ST_MUL_AX = 4'd2;
   localparam logic [3:0] ST_ADD_B  = 4'd3;
   localparam logic [3:0] ST_MUL_SX = 4'd4;
   localparam logic [3:0] ST_ADD_C  = 4'd5;
   localparam logic [3:0] ST_DONE   = 4'd6;
   localparam logic [3:0] ST_MUL_BX = 4'd7;
   localparam logic [3:0] ST_ADD_SC = 4'd8;

   // M0: constant-operand select
   localparam logic [1:0] SEL0_Z  = 2'b00;
   localparam logic [1:0] SEL0_A  = 2'b01;
   localparam logic [1:0] SEL0_B  = 2'b10;
   localparam logic [1:0] SEL0_C  = 2'b11;

   // M1: ALU left operand select
   localparam logic [1:0] SEL1_M0 = 2'b00;
   localparam logic [1:0] SEL1_X  = 2'b01;
   localparam logic [1:0] SEL1_S  = 2'b10;
   localparam logic [1:0] SEL1_H  = 2'b11;

   // M2: ALU right operand select
   localparam logic [1:0] SEL2_X  = 2'b00;
   localparam logic [1:0] SEL2_M0 = 2'b01;
   localparam logic [1:0] SEL2_S  = 2'b10;
   localparam logic [1:0] SEL2_H  = 2'b11;

   // ALU operation
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   // States whose closing edge latches an ALU result (overflow is tracked here)
   function automatic logic is_compute(input logic [3:0] st);
      return (st == ST_MUL_AX) || (st == ST_ADD_B) || (st == ST_MUL_SX) ||
             (st == ST_ADD_C)  || (st == ST_MUL_BX) || (st == ST_ADD_SC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/done_timer.sv
`default_nettype none
// ============================================================================
// Module      : done_timer
// Description : Down-counter that sets how long the controller stays in DONE.
//               It is loaded with DONE_CYCLES-1 when DONE is entered. The
//               counter decrements while DONE is active, and expire marks the
//               last DONE cycle.
// Ports       : clk    - system clock, rising edge
//               rst    - asynchronous active-low reset
//               load   - load counter (entry into DONE)
//               dec    - decrement (in DONE)
//               expire - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module done_timer #(
   parameter int DONE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic expire
);

   localparam logic [3:0] C_LOAD_VAL = 4'(DONE_CYCLES - 1);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= 4'd0;
      end else if (load) begin
         r_cnt <= C_LOAD_VAL;
      end else if (dec && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign expire = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module      : control
// Description : Sequencer for the expression-solver datapath. It evaluates
//               y = A*X^2 + B*X + C in Horner form: S=A*X; S=S+B; H=S*X;
//               H=H+C. Control outputs are a Moore decode of the state. ovf is
//               a sticky overflow flag that is cleared on an accepted start.
//               Optional macro EXPR_LINEAR_MODE_EN enables mode=1. That mode
//               runs the linear sequence S=B*X; H=S+C.
// Ports       : clk, rst(async, active-low), start, mode, zero, overflow (in)
//               LX/LS/LH register loads, H ALU op, M0/M1/M2 mux selects,
//               busy, done, ovf, res_zero (out)
// Revision    : 1.0 - initial release
// ============================================================================
module control
   import expr_pkg::*;
#(
   parameter int DONE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       zero,
   input  logic       overflow,
   output logic       LX,
   output logic       LS,
   output logic       LH,
   output logic       H,
   output logic [1:0] M0,
   output logic [1:0] M1,
   output logic [1:0] M2,
   output logic       busy,
   output logic       done,
   output logic       ovf,
   output logic       res_zero
);

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic       r_ovf;
   logic       w_expire;
   logic       w_accept;

   assign w_accept = (r_state == ST_IDLE) && start;

`ifdef EXPR_LINEAR_MODE_EN
   // Mode is captured with start so that a mid-run change has no effect
   logic r_mode;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode <= 1'b0;
      end else if (w_accept) begin
         r_mode <= mode;
      end
   end
`else
   logic w_unused_mode;
   assign w_unused_mode = mode;
`endif

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_LOAD_X;
`ifdef EXPR_LINEAR_MODE_EN
         ST_LOAD_X: w_next = r_mode ? ST_MUL_BX : ST_MUL_AX;
         ST_MUL_BX: w_next = ST_ADD_SC;
         ST_ADD_SC: w_next = ST_DONE;
`else
         ST_LOAD_X: w_next = ST_MUL_AX;
`endif
         ST_MUL_AX: w_next = ST_ADD_B;
         ST_ADD_B:  w_next = ST_MUL_SX;
         ST_MUL_SX: w_next = ST_ADD_C;
         ST_ADD_C:  w_next = ST_DONE;
         ST_DONE:   if (w_expire) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Sticky overflow flag. It accumulates only at the closing edge of compute states.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= 1'b0;
      end else if (is_compute(r_state)) begin
         r_ovf <= r_ovf | overflow;
      end
   end

   done_timer #(
      .DONE_CYCLES (DONE_CYCLES)
   ) u_done_timer (
      .clk    (clk),
      .rst    (rst),
      .load   ((w_next == ST_DONE) && (r_state != ST_DONE)),
      .dec    (r_state == ST_DONE),
      .expire (w_expire)
   );

   // Moore output decode
   always_comb begin
      LX = 1'b0;
      LS = 1'b0;
      LH = 1'b0;
      H  = OP_ADD;
      M0 = SEL0_Z;
      M1 = SEL1_M0;
      M2 = SEL2_X;
      case (r_state)
         ST_LOAD_X: LX = 1'b1;
         ST_MUL_AX: begin
            M0 = SEL0_A; M1 = SEL1_M0; M2 = SEL2_X;  H = OP_MUL; LS = 1'b1;
         end
         ST_ADD_B: begin
            M0 = SEL0_B; M1 = SEL1_S;  M2 = SEL2_M0; H = OP_ADD; LS = 1'b1;
         end
         ST_MUL_SX: begin
            M1 = SEL1_S; M2 = SEL2_X; H = OP_MUL; LH = 1'b1;
         end
         ST_ADD_C: begin
            M0 = SEL0_C; M1 = SEL1_H;  M2 = SEL2_M0; H = OP_ADD; LH = 1'b1;
         end
`ifdef EXPR_LINEAR_MODE_EN
         ST_MUL_BX: begin
            M0 = SEL0_B; M1 = SEL1_M0; M2 = SEL2_X;  H = OP_MUL; LS = 1'b1;
         end
         ST_ADD_SC: begin
            M0 = SEL0_C; M1 = SEL1_S;  M2 = SEL2_M0; H = OP_ADD; LH = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign ovf      = r_ovf;
   assign res_zero = done & zero;

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_control
// Description : Directed self-checking bench for control. A small behavioural
//               datapath (16-bit signed, X sign-extended from 8 bits) is
//               driven by the controller. The datapath result is checked
//               against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control;

   localparam int DC = 3;

   logic clk = 1'b0;
   logic rst_n, start, mode, ovf_force;
   logic LX, LS, LH, H, busy, done, ovf, res_zero, zero, overflow;
   logic [1:0] M0, M1, M2;

   always #5 clk = ~clk;

   control #(.DONE_CYCLES(DC)) dut (
      .clk(clk), .rst(rst_n), .start(start), .mode(mode), .zero(zero),
      .overflow(overflow), .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0),
      .M1(M1), .M2(M2), .busy(busy), .done(done), .ovf(ovf),
      .res_zero(res_zero)
   );

   // ---------------- behavioural datapath ----------------
   logic signed [15:0] ra, rb, rc;
   logic signed [7:0]  xin;
   logic signed [15:0] rx, rs, rh;
   logic signed [15:0] m0o, m1o, m2o, alu;
   logic signed [31:0] prod;
   logic signed [16:0] sum;
   logic               ov_alu;

   always_comb begin
      case (M0)
         2'b00: m0o = 16'sd0;
         2'b01: m0o = ra;
         2'b10: m0o = rb;
         default: m0o = rc;
      endcase
      case (M1)
         2'b00: m1o = m0o;
         2'b01: m1o = rx;
         2'b10: m1o = rs;
         default: m1o = rh;
      endcase
      case (M2)
         2'b00: m2o = rx;
         2'b01: m2o = m0o;
         2'b10: m2o = rs;
         default: m2o = rh;
      endcase
      prod = 32'(m1o) * 32'(m2o);
      sum  = 17'(m1o) + 17'(m2o);
      if (H) begin
         alu    = prod[15:0];
         ov_alu = (prod != {{16{prod[15]}}, prod[15:0]});
      end else begin
         alu    = sum[15:0];
         ov_alu = (sum[16] != sum[15]);
      end
   end

   assign overflow = ov_alu | ovf_force;
   assign zero     = (rh == 16'sd0);

   always @(posedge clk) begin
      if (LX) rx <= {{8{xin[7]}}, xin};
      if (LS) rs <= alu;
      if (LH) rh <= alu;
   end

   // ---------------- checking ----------------
   int n_total = 0;
   int n_pass  = 0;

   wire [9:0] ctl = {LX, LS, LH, H, M0, M1, M2};

   // expected control word per cycle of the quadratic sequence (index = cycle)
   logic [9:0] exp_ctl [1:5];
   initial begin
      exp_ctl[1] = 10'b1_0_0_0_00_00_00;  // LOAD_X
      exp_ctl[2] = 10'b0_1_0_1_01_00_00;  // MUL_AX
      exp_ctl[3] = 10'b0_1_0_0_10_10_01;  // ADD_B
      exp_ctl[4] = 10'b0_0_1_1_00_10_00;  // MUL_SX
      exp_ctl[5] = 10'b0_0_1_0_11_11_01;  // ADD_C
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] c, input logic signed [7:0] x);
      ra = a; rb = b; rc = c; xin = x;
   endtask

   int first_rise, second_rise, nrise, dcnt;
   logic pd;

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; ovf_force = 1'b0;
      set_ops(16'sd0, 16'sd0, 16'sd0, 8'sd0);
      #12;
      chk("reset_outputs", {18'd0, ctl, busy, done, ovf, res_zero}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step(); step();

      // ---- basic quadratic run: 1*16 + 2*4 + 3 = 27 ----
      set_ops(16'sd1, 16'sd2, 16'sd3, 8'sd4);
      start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("ctl_c1", {22'd0, ctl}, {22'd0, exp_ctl[1]});
      for (int i = 2; i <= 5; i++) begin
         step();
         chk($sformatf("ctl_c%0d", i), {22'd0, ctl}, {22'd0, exp_ctl[i]});
      end
      chk("done_not_early", {31'd0, done}, 32'd0);
      step();                                   // cycle 6
      chk("done_c6", {31'd0, done}, 32'd1);
      chk("result_27", 32'(rh), 32'd27);
      chk("ovf_clean", {31'd0, ovf}, 32'd0);
      chk("res_zero_0", {31'd0, res_zero}, 32'd0);
      chk("ctl_done", {22'd0, ctl}, 32'd0);
      start = 1'b1;                             // ignored during DONE
      step();
      start = 1'b0;
      step();
      chk("done_c8", {31'd0, done}, 32'd1);
      step();                                   // cycle 9 -> IDLE
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
      step();
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);

      // ---- overflow outside compute states is ignored ----
      ovf_force = 1'b1;
      step();
      ovf_force = 1'b0;
      chk("ovf_ignored_idle", {31'd0, ovf}, 32'd0);

      // ---- zero result: 4 - 8 + 4 = 0 ----
      set_ops(16'sd1, -16'sd4, 16'sd4, 8'sd2);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_result", 32'(rh), 32'd0);
      chk("res_zero_1", {31'd0, res_zero}, 32'd1);
      chk("zero_ovf", {31'd0, ovf}, 32'd0);
      repeat (DC) step();
      chk("res_zero_needs_done", {31'd0, res_zero}, 32'd0);

      // ---- overflow: 0x7FFF * 127 ----
      set_ops(16'sh7FFF, 16'sd0, 16'sd0, 8'sd127);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("ovf_at_done", {31'd0, ovf}, 32'd1);
      repeat (DC) step();
      chk("ovf_hold_idle", {30'd0, busy, ovf}, 32'd1);
      step();
      chk("ovf_hold_idle2", {31'd0, ovf}, 32'd1);
      set_ops(16'sd1, 16'sd2, 16'sd3, 8'sd4);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ovf_cleared_on_start", {31'd0, ovf}, 32'd0);
      repeat (5) step();
      chk("after_ovf_result", 32'(rh), 32'd27);
      chk("after_ovf_flag", {31'd0, ovf}, 32'd0);
      repeat (DC) step();

      // ---- start held high: back-to-back every 6+DC cycles ----
      first_rise = -1; second_rise = -1; nrise = 0; pd = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 27; c++) begin
         step();
         if (done && !pd) begin
            nrise++;
            if (nrise == 1) first_rise = c;
            if (nrise == 2) second_rise = c;
            chk("btb_result", 32'(rh), 32'd27);
         end
         pd = done;
      end
      start = 1'b0;
      chk("btb_first", 32'(first_rise), 32'd6);
      chk("btb_second", 32'(second_rise), 32'(6 + (6 + DC)));
      chk("btb_count", 32'(nrise), 32'd3);
      step();
      chk("btb_idle", {31'd0, busy}, 32'd0);

      // ---- asynchronous reset during ADD_B ----
      set_ops(16'sd1, 16'sd2, 16'sd3, 8'sd4);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();                           // cycle 3 = ADD_B
      chk("ctl_add_b", {22'd0, ctl}, {22'd0, exp_ctl[3]});
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {18'd0, ctl, busy, done, ovf, res_zero}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("post_reset_done", {31'd0, done}, 32'd1);
      chk("post_reset_result", 32'(rh), 32'd27);
      repeat (DC) step();

`ifdef EXPR_LINEAR_MODE_EN
      // ---- linear mode: 5*2 - 10 = 0, done in cycle 4 ----
      set_ops(16'sd0, 16'sd5, -16'sd10, 8'sd2);
      mode  = 1'b1;
      start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      mode  = 1'b0;                             // must be held internally
      chk("lin_ctl_c1", {22'd0, ctl}, {22'd0, exp_ctl[1]});
      step();
      chk("lin_ctl_mul_bx", {22'd0, ctl}, {22'd0, 10'b0_1_0_1_10_00_00});
      step();
      chk("lin_ctl_add_sc", {22'd0, ctl}, {22'd0, 10'b0_0_1_0_11_10_01});
      step();                                   // cycle 4
      chk("lin_done_c4", {31'd0, done}, 32'd1);
      chk("lin_result", 32'(rh), 32'd0);
      chk("lin_res_zero", {31'd0, res_zero}, 32'd1);
`else
      // ---- mode ignored: quadratic sequence regardless ----
      set_ops(16'sd1, 16'sd2, 16'sd3, 8'sd4);
      mode  = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("mode_ignored_ctl", {22'd0, ctl}, {22'd0, exp_ctl[2]});
      repeat (4) step();                        // cycle 6
      chk("mode_ignored_done", {31'd0, done}, 32'd1);
      chk("mode_ignored_result", 32'(rh), 32'd27);
      mode = 1'b0;
`endif
      // done stays high for exactly DC cycles
      dcnt = 1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (!done) break;
         dcnt++;
      end
      chk("done_length", 32'(dcnt), 32'(DC));
      chk("final_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control.md
Name: control

Overview:
- FSM controller that drives the operative datapath to evaluate y = A*X^2 + B*X + C in Horner form: S=A*X; S=S+B; H=S*X; H=H+C.
- Issues register loads (LX, LS, LH), the ALU op select (H) and the mux selects (M0, M1, M2).
- Consumes the datapath's zero and overflow, and presents a start/busy/done handshake to the top level.
- Sits beside the datapath inside the expression-solver top.

Parameters:
- DONE_CYCLES, 1, number of cycles done stays high after a computation (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a computation; sampled only in IDLE
- mode  in  1  0 = quadratic, 1 = linear (only with EXPR_LINEAR_MODE_EN; ignored otherwise)
- zero  in  1  datapath: Reg_H == 0
- overflow  in  1  datapath: ALU overflow in the current cycle
- LX  out  1  load Reg_X
- LS  out  1  load Reg_S
- LH  out  1  load Reg_H
- H  out  1  ALU op: 0 = add, 1 = multiply
- M0  out  2  00 = zero, 01 = A, 10 = B, 11 = C
- M1  out  2  00 = M0_out, 01 = Reg_X, 10 = Reg_S, 11 = Reg_H
- M2  out  2  00 = Reg_X, 01 = M0_out, 10 = Reg_S, 11 = Reg_H
- busy  out  1  high in every state except IDLE
- done  out  1  result valid on datapath result
- ovf  out  1  sticky overflow for the current or last computation
- res_zero  out  1  done & zero

Behaviour:
- Reset (rst=0, async):
  - state = IDLE, done counter = 0, ovf = 0.
  - All outputs 0: LX=LS=LH=H=0, M0=M1=M2=00, busy=done=res_zero=0.
  - Reset mid-computation aborts immediately; datapath register contents are don't-care afterwards.
- Control outputs are a Moore decode of the state register. ovf and the done counter are registered.
- States and per-state decode (signals not listed are 0 / 00):
  - IDLE: all controls 0. start=1 -> LOAD_X, and ovf clears at the same edge.
  - LOAD_X: LX=1. -> MUL_AX (quadratic), or MUL_BX (linear).
  - MUL_AX: M0=01, M1=00, M2=00, H=1, LS=1. -> ADD_B.
  - ADD_B: M0=10, M1=10, M2=01, H=0, LS=1. -> MUL_SX.
  - MUL_SX: M1=10, M2=00, H=1, LH=1. -> ADD_C.
  - ADD_C: M0=11, M1=11, M2=01, H=0, LH=1. -> DONE.
  - DONE: done=1. Stays for DONE_CYCLES cycles (down-counter loaded on entry), then -> IDLE.
- Latency: start sampled at edge 0 -> done first high in cycle 6 (quadratic) or cycle 4 (linear).
  - Throughput: one computation per 6+DONE_CYCLES cycles.
- Handshake and overflow:
  - start while busy (including during DONE) is ignored; it is not queued.
  - ovf |= overflow at every edge that ends a compute state (MUL_*/ADD_*). It holds through DONE and IDLE until the next accepted start.
  - Overflow outside compute states is ignored.
- Width: the controller does no arithmetic. The datapath is 16-bit signed with X sign-extended from 8 bits; overflow is defined by the ALU.
- DONE_CYCLES=0 is illegal; behaviour is undefined.

Optional Feature:
- Macro: EXPR_LINEAR_MODE_EN.
- Defined:
  - mode is sampled together with start and held in a register for the whole computation.
  - mode=1 sequence: LOAD_X -> MUL_BX -> ADD_SC -> DONE.
  - MUL_BX: M0=10, M1=00, M2=00, H=1, LS=1.
  - ADD_SC: M0=11, M1=10, M2=01, H=0, LH=1.
  - Result is B*X + C.
- Undefined: the mode port exists but is ignored; only the quadratic sequence is used.

Decomposition:
- Shared package (expr_pkg):
  - state enum.
  - M0/M1/M2 select constants (SEL0_Z/A/B/C, SEL1_M0/X/S/H, SEL2_X/M0/S/H).
  - ALU op constants (OP_ADD=0, OP_MUL=1).
  - The datapath uses the same constants.
- One natural sub-module: done_timer, a DONE_CYCLES down-counter with load and expire outputs.

Test Plan:
- A=1, B=2, C=3, X=4, pulse start -> busy next cycle; done in cycle 6; result=27; ovf=0; res_zero=0.
- A=1, B=-4, C=4, X=2 -> result=0, res_zero=1 during done, ovf=0.
- A=16'h7FFF, B=0, C=0, X=127 -> ovf=1 at done and held in IDLE; a next start with A=1, B=2, C=3, X=4 clears ovf to 0.
- start held high continuously -> computations back-to-back every 6+DONE_CYCLES cycles; pulses during busy produce no extra runs.
- rst low during ADD_B -> all outputs 0 immediately; after release plus start, A=1, B=2, C=3, X=4 gives 27.
- With EXPR_LINEAR_MODE_EN, mode=1, B=5, C=-10, X=2 -> done in cycle 4, result=0, res_zero=1; DONE_CYCLES=3 -> done high exactly 3 cycles.
